data_ram_arbiter: RTL and testbench
===================================

// Module: data_ram_arbiter
// PURPOSE
//  Shares the single-port data_ram between two requesters: port 0 (CPU load/store) and port 1 (DMA).
//  Arbitrates between them, registers the winning command and drives the RAM data/addr/we pins.
//  Returns the registered-address read data one cycle after the access, with per-port done/rvalid.
//  Sits between the core/DMA and data_ram.
// PARAMETERS
//  DWIDTH      16  data width; matches data_ram DWIDTH
//  ADDR_WIDTH  17  address width; matches data_ram ADDR_WIDTH
// PORTS
//  clk        in   1           single system clock, rising edge
//  rst        in   1           asynchronous reset, active-high
//  req        in   2           per-port request; held high until gnt seen
//  req_we     in   2           per-port write enable (1=write, 0=read); valid with req
//  req_addr0  in   ADDR_WIDTH  port 0 address
//  req_addr1  in   ADDR_WIDTH  port 1 address
//  req_wdata0 in   DWIDTH      port 0 write data
//  req_wdata1 in   DWIDTH      port 1 write data
//  gnt        out  2           one-hot, 1-cycle pulse: command accepted
//  done       out  2           one-hot, 1-cycle pulse: access complete (write or read)
//  rvalid     out  2           one-hot, 1 cycle: rdata valid for that port (reads only)
//  rdata      out  DWIDTH      read data, shared; valid only with rvalid
//  ram_addr   out  ADDR_WIDTH  to data_ram addr
//  ram_din    out  DWIDTH      to data_ram data
//  ram_we     out  1           to data_ram we
//  ram_dout   in   DWIDTH      from data_ram dout
// BEHAVIOUR
//  FSM states: IDLE, ACCESS, RESP. All outputs are 0 in reset; FSM resets to IDLE, last_winner=1.
//  IDLE: if req!=0 at a clk edge: pick winner, latch we/addr/wdata; go to ACCESS with gnt[w]=1.
//  ACCESS (1 cycle): ram_addr/ram_din = latched values; ram_we = latched we.
//   Write: data_ram writes at the end of ACCESS. Next state IDLE; done[w]=1 for 1 cycle.
//   Read: data_ram captures addr_reg at the end of ACCESS. Next state RESP.
//  RESP (1 cycle): rvalid[w]=1, done[w]=1, rdata=ram_dout. Next state IDLE.
//  Latency from req sampled: gnt +1 cycle; write done +2; read rvalid/done +2. One access in flight.
//  Throughput: write every 2 cycles, read every 3 cycles.
//  Outside ACCESS: ram_we=0; ram_addr/ram_din hold their last values (keeps RAM addr_reg stable).
//  Arbitration (round-robin):
//   Single requester wins. On conflict, the port != last_winner wins.
//   last_winner updates on every grant.
//  req is ignored in ACCESS/RESP. A req still high in IDLE after done is a new request.
//  Addresses and data pass unchanged: no truncation or extension.
//  Reset mid-access: return to IDLE asynchronously; ram_we, gnt, done and rvalid drop at once.
//   The aborted access is neither completed nor retried.
//  rdata equals ram_dout whenever rvalid=0 (don't-care), with no extra register.
// CONFIGURATION
//  RAM_ARB_FIXED_PRIO_EN defined: port 0 always wins conflicts; last_winner is unused.
//  RAM_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
// STRUCTURE
//  Package data_ram_arb_pkg holds:
//   - state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
//   - PORT_CPU=0, PORT_DMA=1
//  Sub-module rr_arbiter_2: inputs req[1:0], last_winner; output one-hot winner.
//   The RAM_ARB_FIXED_PRIO_EN ifdef lives inside it.
//  data_ram_arbiter holds the FSM, latched command and output muxing.
// TESTING (bench instantiates data_ram)
//  1. P0 write addr=0x00010, wdata=0xBEEF.
//     -> gnt=01 at +1, ram_we=1 at +1, done=01 at +2.
//     Then P0 read 0x00010 -> rvalid=01, rdata=0xBEEF at +2.
//  2. req=11 same cycle after reset (both reads).
//     -> P0 granted first, P1 granted in the IDLE cycle after P0 done.
//     Rerun with RAM_ARB_FIXED_PRIO_EN and req held at 11 -> P0 granted every time.
//  3. Both ports request continuously, 6 accesses -> gnt sequence 01,10,01,10,01,10.
//     Never the same port twice while the other waits.
//  4. P1 write 0x1FFFF=0x1234, then P1 read 0x1FFFF.
//     -> rdata=0x1234; ram_addr never truncated.
//  5. Assert rst during ACCESS of a write.
//     -> ram_we=0 immediately, no done.
//     After release, state IDLE and the next req is granted at +1.

Source files
------------

// File: rtl/data_ram_arb_pkg.sv
// -----------------------------------------------------------------------------
// data_ram_arb_pkg
// Shared definitions for the data_ram arbiter: FSM state encoding and the
// indices of the two requesting ports.
// -----------------------------------------------------------------------------
package data_ram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   localparam int PORT_CPU = 0;
   localparam int PORT_DMA = 1;

   // One-hot port mask for a port index.
   function automatic logic [1:0] port_mask(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way arbiter. A lone requester always wins. On a conflict the port that
// did not win last time gets the grant (round-robin), unless the build defines
// RAM_ARB_FIXED_PRIO_EN, in which case port 0 always wins conflicts.
// Ports:
//   req[1:0]     in   request per port
//   last_winner  in   index of the most recently granted port
//   winner[1:0]  out  one-hot winner, 2'b00 when nobody requests
// Configuration macro: RAM_ARB_FIXED_PRIO_EN
// -----------------------------------------------------------------------------
module rr_arbiter_2
   import data_ram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_winner,
   output logic [1:0] winner
);

`ifdef RAM_ARB_FIXED_PRIO_EN
   // Priority is fixed, so the history input has no effect.
   logic unused_last_winner;
   assign unused_last_winner = last_winner;
`endif

   always_comb begin
      winner = 2'b00;
      case (req)
         2'b01: winner = 2'b01;
         2'b10: winner = 2'b10;
         2'b11: begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            winner = port_mask(1'(PORT_CPU));
`else
            winner = (last_winner == 1'(PORT_CPU)) ? port_mask(1'(PORT_DMA))
                                                   : port_mask(1'(PORT_CPU));
`endif
         end
         default: winner = 2'b00;
      endcase
   end

endmodule

// File: rtl/data_ram_arbiter.sv
// -----------------------------------------------------------------------------
// data_ram_arbiter
// Shares the single-port data_ram between the CPU (port 0) and DMA (port 1).
// The winning command is latched into registers that drive the RAM pins
// directly; read data comes straight from the RAM's registered-address output
// one cycle after the access.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req[1:0], req_we[1:0] per-port request / write enable, held until gnt
//   req_addr0/1           per-port address
//   req_wdata0/1          per-port write data
//   gnt[1:0]              one-cycle pulse: command accepted
//   done[1:0]             one-cycle pulse: access complete
//   rvalid[1:0]           one cycle: rdata valid for that port (reads)
//   rdata                 read data (mirrors ram_dout at all times)
//   ram_addr/ram_din/ram_we  to data_ram
//   ram_dout              from data_ram
// Configuration macro: RAM_ARB_FIXED_PRIO_EN (forwarded to rr_arbiter_2).
// -----------------------------------------------------------------------------
module data_ram_arbiter
   import data_ram_arb_pkg::*;
#(
   parameter int DWIDTH     = 16,
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req,
   input  logic [1:0]            req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr0,
   input  logic [ADDR_WIDTH-1:0] req_addr1,
   input  logic [DWIDTH-1:0]     req_wdata0,
   input  logic [DWIDTH-1:0]     req_wdata1,
   output logic [1:0]            gnt,
   output logic [1:0]            done,
   output logic [1:0]            rvalid,
   output logic [DWIDTH-1:0]     rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0]     ram_din,
   output logic                  ram_we,
   input  logic [DWIDTH-1:0]     ram_dout
);

   arb_state_t            state_q, state_d;
   logic                  last_winner_q, last_winner_d;
   logic                  port_q, port_d;
   logic                  cmd_we_q, cmd_we_d;
   logic [1:0]            gnt_q, gnt_d;
   logic [1:0]            done_q, done_d;
   logic [1:0]            rvalid_q, rvalid_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DWIDTH-1:0]     ram_din_q, ram_din_d;
   logic                  ram_we_q, ram_we_d;
   logic [1:0]            winner;

   rr_arbiter_2 u_arb (
      .req         (req),
      .last_winner (last_winner_q),
      .winner      (winner)
   );

   always_comb begin
      state_d       = state_q;
      last_winner_d = last_winner_q;
      port_d        = port_q;
      cmd_we_d      = cmd_we_q;
      gnt_d         = 2'b00;
      done_d        = 2'b00;
      rvalid_d      = 2'b00;
      ram_we_d      = 1'b0;
      // Address/data hold between accesses so the RAM's address register
      // keeps pointing at the last location.
      ram_addr_d    = ram_addr_q;
      ram_din_d     = ram_din_q;

      case (state_q)
         IDLE: begin
            if (winner != 2'b00) begin
               port_d        = winner[1];
               cmd_we_d      = req_we[winner[1]];
               ram_addr_d    = winner[1] ? req_addr1 : req_addr0;
               ram_din_d     = winner[1] ? req_wdata1 : req_wdata0;
               ram_we_d      = req_we[winner[1]];
               gnt_d         = winner;
               last_winner_d = winner[1];
               state_d       = ACCESS;
            end
         end
         ACCESS: begin
            // Write completes at the end of ACCESS; a read needs one more
            // cycle for the RAM output to reflect the captured address.
            done_d = port_mask(port_q);
            if (cmd_we_q) begin
               state_d = IDLE;
            end else begin
               rvalid_d = port_mask(port_q);
               state_d  = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         last_winner_q <= 1'(PORT_DMA);
         port_q        <= 1'b0;
         cmd_we_q      <= 1'b0;
         gnt_q         <= 2'b00;
         done_q        <= 2'b00;
         rvalid_q      <= 2'b00;
         ram_addr_q    <= '0;
         ram_din_q     <= '0;
         ram_we_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_winner_q <= last_winner_d;
         port_q        <= port_d;
         cmd_we_q      <= cmd_we_d;
         gnt_q         <= gnt_d;
         done_q        <= done_d;
         rvalid_q      <= rvalid_d;
         ram_addr_q    <= ram_addr_d;
         ram_din_q     <= ram_din_d;
         ram_we_q      <= ram_we_d;
      end
   end

   assign gnt      = gnt_q;
   assign done     = done_q;
   assign rvalid   = rvalid_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;
   assign ram_we   = ram_we_q;
   assign rdata    = ram_dout;

endmodule

// File: tb/tb_data_ram_arbiter.sv
module tb_data_ram_arbiter;

   localparam int DW = 16;
   localparam int AW = 17;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req, req_we, gnt, done, rvalid;
   logic [AW-1:0] req_addr0, req_addr1, ram_addr;
   logic [DW-1:0] req_wdata0, req_wdata1, rdata, ram_din, ram_dout;
   logic          ram_we;

   always #5 clk = ~clk;

   data_ram_arbiter #(.DWIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_we     (req_we),
      .req_addr0  (req_addr0),
      .req_addr1  (req_addr1),
      .req_wdata0 (req_wdata0),
      .req_wdata1 (req_wdata1),
      .gnt        (gnt),
      .done       (done),
      .rvalid     (rvalid),
      .rdata      (rdata),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din),
      .ram_we     (ram_we),
      .ram_dout   (ram_dout)
   );

   // data_ram stand-in: synchronous write, registered read address.
   logic [DW-1:0] ram_mem [0:DEPTH-1];
   logic [AW-1:0] ram_addr_reg = '0;
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_addr_reg <= ram_addr;
   end
   assign ram_dout = ram_mem[ram_addr_reg];

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } cmd_t;

   typedef struct {
      int            due;
      int            port;
      logic          is_rd;
      logic [DW-1:0] data;
   } resp_t;

   // Reference model state
   logic [DW-1:0] mem_m [0:DEPTH-1];
   cmd_t          cmdq0[$], cmdq1[$];
   cmd_t          pend [2];
   logic          pend_v [2];
   resp_t         sbq[$];
   int            gseq[$];
   int            next_free = 0;
   int            last_w = 1;
   logic [1:0]    req_prev = 2'b00;
   int            last_grant_cyc = -1;
   logic          last_grant_we = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_old = '0;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Arbitration rule: lone requester wins; on conflict the port that did not
   // win last time (or port 0 under fixed priority).
   function automatic int pick(input logic [1:0] r, input int last);
      if (r == 2'b11) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
         return 0;
`else
         return 1 - last;
`endif
      end
      return r[1] ? 1 : 0;
   endfunction

   function automatic cmd_t rand_cmd();
      cmd_t c;
      c.we    = 1'($urandom_range(0, 1));
      c.addr  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7))
                                            : AW'(32'h1FFF8 + $urandom_range(0, 7));
      c.wdata = DW'($urandom);
      return c;
   endfunction

   task automatic load_and_drive(input bit rand_fill, input int pct);
      if (!pend_v[0]) begin
         if (cmdq0.size() > 0) begin pend[0] = cmdq0.pop_front(); pend_v[0] = 1'b1; end
         else if (rand_fill && $urandom_range(0, 99) < pct) begin pend[0] = rand_cmd(); pend_v[0] = 1'b1; end
      end
      if (!pend_v[1]) begin
         if (cmdq1.size() > 0) begin pend[1] = cmdq1.pop_front(); pend_v[1] = 1'b1; end
         else if (rand_fill && $urandom_range(0, 99) < pct) begin pend[1] = rand_cmd(); pend_v[1] = 1'b1; end
      end
      req        = {pend_v[1], pend_v[0]};
      req_we     = {pend[1].we, pend[0].we};
      req_addr0  = pend[0].addr;
      req_addr1  = pend[1].addr;
      req_wdata0 = pend[0].wdata;
      req_wdata1 = pend[1].wdata;
      req_prev   = req;
   endtask

   // One clock: predict what the last rising edge should have done, compare,
   // then drive the next request set.
   task automatic step(input bit rand_fill, input int pct);
      int         w;
      logic [1:0] exp_gnt;
      logic       exp_we;
      @(negedge clk);
      exp_gnt = 2'b00;
      exp_we  = 1'b0;
      if (req_prev != 2'b00 && cyc >= next_free) begin
         w = pick(req_prev, last_w);
         last_w = w;
         exp_gnt[w] = 1'b1;
         gseq.push_back(w + 1);
         last_grant_cyc = cyc;
         last_grant_we  = pend[w].we;
         $display("txn cyc=%0d port=%0d %s addr=%05h wdata=%04h", cyc, w,
                  pend[w].we ? "WR" : "RD", pend[w].addr, pend[w].wdata);
         chk("ram_addr", 32'(ram_addr), 32'(pend[w].addr));
         if (pend[w].we) begin
            exp_we = 1'b1;
            chk("ram_din", 32'(ram_din), 32'(pend[w].wdata));
            wr_addr = pend[w].addr;
            wr_old  = mem_m[pend[w].addr];
            mem_m[pend[w].addr] = pend[w].wdata;
            sbq.push_back('{cyc + 1, w, 1'b0, '0});
            next_free = cyc + 2;
         end else begin
            sbq.push_back('{cyc + 1, w, 1'b1, mem_m[pend[w].addr]});
            next_free = cyc + 3;
         end
         pend_v[w] = 1'b0;
      end
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("ram_we", 32'(ram_we), 32'(exp_we));
      load_and_drive(rand_fill, pct);
   endtask

   task automatic do_reset(input bit abort_write);
      if (abort_write) mem_m[wr_addr] = wr_old;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      next_free = 0;
      last_w = 1;
      sbq.delete();
      load_and_drive(1'b0, 0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((cmdq0.size() > 0 || cmdq1.size() > 0 || pend_v[0] || pend_v[1] ||
              sbq.size() > 0 || cyc < next_free) && n < 300) begin
         step(1'b0, 0);
         n++;
      end
      if (n >= 300) chk("drain_timeout", 32'(n), 32'(0));
      step(1'b0, 0);
   endtask

   // Monitor: pops the expected response whenever the DUT reports completion.
   resp_t      mon_e;
   logic [1:0] mon_mask;
   always @(negedge clk) begin
      if (!rst) begin
         if (done != 2'b00 || rvalid != 2'b00) begin
            if (sbq.size() == 0) begin
               chk("spurious_done", 32'({done, rvalid}), 32'(0));
            end else begin
               mon_e    = sbq.pop_front();
               mon_mask = 2'b01 << mon_e.port;
               chk("done", 32'(done), 32'(mon_mask));
               chk("rvalid", 32'(rvalid), mon_e.is_rd ? 32'(mon_mask) : 32'(0));
               chk("resp_cycle", 32'(cyc), 32'(mon_e.due));
               if (mon_e.is_rd) chk("rdata", 32'(rdata), 32'(mon_e.data));
            end
         end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
            chk("resp_timeout", 32'(cyc), 32'(sbq[0].due));
            void'(sbq.pop_front());
         end
      end
   end

   initial begin
      int n;
      for (int i = 0; i < DEPTH; i++) begin
         ram_mem[i] = '0;
         mem_m[i]   = '0;
      end
      pend[0] = '{1'b0, '0, '0};
      pend[1] = '{1'b0, '0, '0};
      pend_v[0] = 1'b0;
      pend_v[1] = 1'b0;
      rst = 1'b1;
      req = 2'b00; req_we = 2'b00;
      req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_rvalid", 32'(rvalid), 32'(0));
      chk("rst_ram_we", 32'(ram_we), 32'(0));
      chk("rst_ram_addr", 32'(ram_addr), 32'(0));
      chk("rst_ram_din", 32'(ram_din), 32'(0));

      // 1: CPU write then read back
      cmdq0.push_back('{1'b1, 17'h00010, 16'hBEEF});
      cmdq0.push_back('{1'b0, 17'h00010, 16'h0000});
      do_reset(1'b0);
      drain();

      // 2: both ports request right after reset
      cmdq0.push_back('{1'b0, 17'h00010, 16'h0000});
      cmdq1.push_back('{1'b0, 17'h00003, 16'h0000});
      gseq.delete();
      do_reset(1'b0);
      drain();
      chk("t2_first", 32'(gseq[0]), 32'(1));
      chk("t2_second", 32'(gseq[1]), 32'(2));

      // 3: continuous requests from both ports
      gseq.delete();
      for (int i = 0; i < 3; i++) begin
         cmdq0.push_back(rand_cmd());
         cmdq1.push_back(rand_cmd());
      end
      load_and_drive(1'b0, 0);
      drain();
      for (int i = 0; i < 6; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
         chk("t3_seq", 32'(gseq[i]), (i < 3) ? 32'(1) : 32'(2));
`else
         chk("t3_seq", 32'(gseq[i]), (i % 2 == 0) ? 32'(1) : 32'(2));
`endif
      end

      // 4: DMA at the top address
      cmdq1.push_back('{1'b1, 17'h1FFFF, 16'h1234});
      cmdq1.push_back('{1'b0, 17'h1FFFF, 16'h0000});
      load_and_drive(1'b0, 0);
      drain();

      // 5: reset in the ACCESS cycle of a write
      cmdq0.push_back('{1'b1, 17'h00010, 16'hDEAD});
      load_and_drive(1'b0, 0);
      n = 0;
      while (last_grant_cyc != cyc && n < 20) begin
         step(1'b0, 0);
         n++;
      end
      if (n >= 20) chk("t5_grant_timeout", 32'(n), 32'(0));
      chk("t5_we_before_rst", 32'(ram_we), 32'(last_grant_we));
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_ram_we", 32'(ram_we), 32'(0));
      chk("t5_rst_gnt", 32'(gnt), 32'(0));
      chk("t5_rst_done", 32'(done), 32'(0));
      pend[1] = '{1'b0, 17'h00010, 16'h0000};
      pend_v[1] = 1'b1;
      do_reset(1'b1);
      drain();

      // Random traffic
      for (int i = 0; i < 400; i++) step(1'b1, 60);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
